// File: rtl/neuron_sweep_scheduler.sv
// neuron_sweep_scheduler: time-step sweep of neuron states through one
// shared processor, plus read-modify-write current injection between steps.
module neuron_sweep_scheduler #(
   parameter int NR_WIDTH       = 56,
   parameter int NR_I_WIDTH     = 16,
   parameter int NUM_NEURONS    = 256,
   parameter int ADDR_WIDTH     = 8,
   parameter int SPK_FIFO_DEPTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  step_start,
   output logic                  step_busy,
   output logic                  step_done,
   output logic                  mem_rd_en,
   output logic [ADDR_WIDTH-1:0] mem_rd_addr,
   input  logic [NR_WIDTH-1:0]   mem_rd_data,
   output logic                  mem_wr_en,
   output logic [ADDR_WIDTH-1:0] mem_wr_addr,
   output logic [NR_WIDTH-1:0]   mem_wr_data,
   output logic [NR_WIDTH-1:0]   proc_in,
   input  logic [NR_WIDTH-1:0]   proc_out,
   input  logic                  proc_fire,
   output logic                  spk_valid,
   input  logic                  spk_ready,
   output logic [ADDR_WIDTH-1:0] spk_addr,
   input  logic                  inj_valid,
   output logic                  inj_ready,
   input  logic [ADDR_WIDTH-1:0] inj_addr,
   input  logic [NR_I_WIDTH-1:0] inj_current
);

   localparam int CW = $clog2(NUM_NEURONS + 1);
   localparam int PW = $clog2(SPK_FIFO_DEPTH);
   localparam logic [CW-1:0] NN   = CW'(NUM_NEURONS);
   localparam logic [CW-1:0] LAST = CW'(NUM_NEURONS - 1);
   localparam logic [PW:0]   ROOM = (PW+1)'(SPK_FIFO_DEPTH - 2);

   typedef enum logic [1:0] {
      IDLE,
      SWEEP,
      INJ_RD,
      INJ_WR
   } state_t;

   state_t state, state_nx;

   logic [CW-1:0]         rc, wc;
   logic                  wb_pend;
   logic [ADDR_WIDTH-1:0] wb_addr;
   logic [ADDR_WIDTH-1:0] inj_addr_q;
   logic [NR_I_WIDTH-1:0] inj_cur_q;
   logic                  done_q;

   logic [ADDR_WIDTH-1:0] fifo_mem [SPK_FIFO_DEPTH];
   logic [PW-1:0]         wp, rp;
   logic [PW:0]           cnt;

   logic                  sw_rd, sw_wb, last_wb;
   logic                  push, pop, inj_acc;
   logic [NR_I_WIDTH:0]   isum;
   logic [NR_I_WIDTH-1:0] isat;

   // sweep gating, fifo strobes and saturating current add
   always_comb begin
      sw_rd   = (state == SWEEP) && (rc < NN) && (cnt <= ROOM);
      sw_wb   = (state == SWEEP) && wb_pend;
      last_wb = sw_wb && (wc == LAST);
      push    = sw_wb && proc_fire;
      pop     = (cnt != '0) && spk_ready;
      inj_acc = (state == IDLE) && !step_start && inj_valid;
      isum    = {mem_rd_data[NR_I_WIDTH-1], mem_rd_data[NR_I_WIDTH-1:0]}
              + {inj_cur_q[NR_I_WIDTH-1], inj_cur_q};
      if (isum[NR_I_WIDTH] != isum[NR_I_WIDTH-1])
         isat = {isum[NR_I_WIDTH], {(NR_I_WIDTH-1){~isum[NR_I_WIDTH]}}};
      else
         isat = isum[NR_I_WIDTH-1:0];
   end

   // next state and RAM / processor strobes
   always_comb begin
      state_nx    = state;
      mem_rd_en   = 1'b0;
      mem_rd_addr = '0;
      mem_wr_en   = 1'b0;
      mem_wr_addr = '0;
      mem_wr_data = '0;
      proc_in     = '0;
      unique case (state)
         IDLE: begin
            if (step_start)
               state_nx = SWEEP;
            else if (inj_valid)
               state_nx = INJ_RD;
         end
         SWEEP: begin
            if (sw_rd) begin
               mem_rd_en   = 1'b1;
               mem_rd_addr = ADDR_WIDTH'(rc);
            end
            if (sw_wb) begin
               proc_in     = mem_rd_data;
               mem_wr_en   = 1'b1;
               mem_wr_addr = wb_addr;
               mem_wr_data = proc_out;
            end
            if (last_wb)
               state_nx = IDLE;
         end
         INJ_RD: begin
            mem_rd_en   = 1'b1;
            mem_rd_addr = inj_addr_q;
            state_nx    = INJ_WR;
         end
         INJ_WR: begin
            mem_wr_en   = 1'b1;
            mem_wr_addr = inj_addr_q;
            mem_wr_data = {mem_rd_data[NR_WIDTH-1:NR_I_WIDTH], isat};
            state_nx    = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // control state, sweep counters and injection latch
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         rc         <= '0;
         wc         <= '0;
         wb_pend    <= 1'b0;
         wb_addr    <= '0;
         done_q     <= 1'b0;
         inj_addr_q <= '0;
         inj_cur_q  <= '0;
      end else begin
         state   <= state_nx;
         done_q  <= last_wb;
         wb_pend <= sw_rd;
         if (state == IDLE && step_start) begin
            rc <= '0;
            wc <= '0;
         end else begin
            if (sw_rd)
               rc <= rc + 1'b1;
            if (sw_wb)
               wc <= wc + 1'b1;
         end
         if (sw_rd)
            wb_addr <= ADDR_WIDTH'(rc);
         if (inj_acc) begin
            inj_addr_q <= inj_addr;
            inj_cur_q  <= inj_current;
         end
      end
   end

   // spike fifo storage
   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wp] <= wb_addr;
   end

   // spike fifo pointers and occupancy
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (push)
            wp <= wp + 1'b1;
         if (pop)
            rp <= rp + 1'b1;
         if (push && !pop)
            cnt <= cnt + 1'b1;
         else if (pop && !push)
            cnt <= cnt - 1'b1;
      end
   end

   assign step_busy = (state == SWEEP);
   assign step_done = done_q;
   assign inj_ready = (state == IDLE) && !step_start;
   assign spk_valid = (cnt != '0);
   assign spk_addr  = spk_valid ? fifo_mem[rp] : '0;

endmodule

// File: tb/tb_neuron_sweep_scheduler.sv
// tb_neuron_sweep_scheduler: cycle reference model with golden RAM and
// spike queue, directed sweeps, stalls, injections and mid-sweep reset.
module tb_neuron_sweep_scheduler;

   localparam int N  = 8;
   localparam int AW = 4;
   localparam int D  = 4;
   localparam int W  = 56;
   localparam int IW = 16;

   logic          clk, rst_n, step_start, step_busy, step_done;
   logic          mem_rd_en, mem_wr_en, proc_fire;
   logic [AW-1:0] mem_rd_addr, mem_wr_addr, spk_addr, inj_addr;
   logic [W-1:0]  mem_rd_data, mem_wr_data, proc_in, proc_out;
   logic          spk_valid, spk_ready, inj_valid, inj_ready;
   logic [IW-1:0] inj_current;

   neuron_sweep_scheduler #(
      .NR_WIDTH(W), .NR_I_WIDTH(IW), .NUM_NEURONS(N),
      .ADDR_WIDTH(AW), .SPK_FIFO_DEPTH(D)
   ) dut (
      .clk(clk), .rst_n(rst_n), .step_start(step_start),
      .step_busy(step_busy), .step_done(step_done),
      .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
      .mem_rd_data(mem_rd_data), .mem_wr_en(mem_wr_en),
      .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
      .proc_in(proc_in), .proc_out(proc_out), .proc_fire(proc_fire),
      .spk_valid(spk_valid), .spk_ready(spk_ready), .spk_addr(spk_addr),
      .inj_valid(inj_valid), .inj_ready(inj_ready),
      .inj_addr(inj_addr), .inj_current(inj_current)
   );

   function automatic logic [W-1:0] pf(input logic [W-1:0] a);
      return {a[55:36] + 20'd1, a[35:16] + 20'd2, a[15:0]};
   endfunction

   function automatic logic [15:0] sat16(input logic [15:0] a,
                                         input logic [15:0] b);
      int s;
      s = int'($signed(a)) + int'($signed(b));
      if (s > 32767) return 16'h7FFF;
      if (s < -32768) return 16'h8000;
      return s[15:0];
   endfunction

   assign proc_out  = pf(proc_in);
   assign proc_fire = proc_in[55];

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   bit armed = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // bench-side state RAM with a preset port
   logic [W-1:0]  ram [0:15];
   logic          pre_en;
   logic [AW-1:0] pre_addr;
   logic [W-1:0]  pre_data;

   always @(posedge clk) begin
      if (pre_en) ram[pre_addr] <= pre_data;
      if (mem_wr_en) ram[mem_wr_addr] <= mem_wr_data;
      if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];
   end

   // reference model: golden RAM, spike queue, sweep progress
   logic [W-1:0]  gram [0:15];
   int            m_mode = 0;
   int            m_next = 0;
   int            m_fly = -1;
   int            m_wbs = 0;
   bit            m_done = 0;
   int            m_q[$];
   int            m_qmax = 0;
   logic [AW-1:0] m_ia;
   logic [IW-1:0] m_ic;
   int            rx[$];
   int            done_cnt = 0;
   int            rd_cnt = 0;

   logic          e_rd, e_wr, e_fire;
   logic [AW-1:0] e_ra, e_wa;
   logic [W-1:0]  e_wd, e_pi;

   always @(negedge clk) begin
      e_rd = 0; e_wr = 0; e_fire = 0;
      e_ra = '0; e_wa = '0; e_wd = '0; e_pi = '0;
      case (m_mode)
         1: begin
            if (m_next < N && m_q.size() <= D - 2) begin
               e_rd = 1; e_ra = m_next[AW-1:0];
            end
            if (m_fly >= 0) begin
               e_wr = 1; e_wa = m_fly[AW-1:0];
               e_pi = gram[e_wa]; e_wd = pf(e_pi); e_fire = e_pi[55];
            end
         end
         2: begin e_rd = 1; e_ra = m_ia; end
         3: begin
            e_wr = 1; e_wa = m_ia;
            e_wd = {gram[m_ia][55:16], sat16(gram[m_ia][15:0], m_ic)};
         end
         default: ;
      endcase
      if (armed) begin
         chk("busy", step_busy, m_mode == 1);
         chk("done", step_done, m_done);
         chk("inj_ready", inj_ready, m_mode == 0 && !step_start);
         chk("rd_en", mem_rd_en, e_rd);
         if (e_rd) chk("rd_addr", mem_rd_addr, e_ra);
         chk("wr_en", mem_wr_en, e_wr);
         if (e_wr) chk("wr_addr", mem_wr_addr, e_wa);
         if (e_wr) chk("wr_data", mem_wr_data, e_wd);
         chk("proc_in", proc_in, e_pi);
         chk("spk_valid", spk_valid, m_q.size() > 0);
         if (m_q.size() > 0) chk("spk_addr", spk_addr, m_q[0]);
      end
      if (step_done) done_cnt++;
      if (mem_rd_en) rd_cnt++;
      if (spk_valid && spk_ready) rx.push_back(int'(spk_addr));
      if (m_q.size() > 0 && spk_ready) void'(m_q.pop_front());
      if (e_wr) gram[e_wa] = e_wd;
      if (m_mode == 1 && e_fire) m_q.push_back(int'(e_wa));
      if (m_q.size() > m_qmax) m_qmax = m_q.size();
      m_done = 0;
      case (m_mode)
         0: begin
            if (step_start) begin
               m_mode = 1; m_next = 0; m_fly = -1; m_wbs = 0;
            end else if (inj_valid) begin
               m_mode = 2; m_ia = inj_addr; m_ic = inj_current;
            end
         end
         1: begin
            if (e_wr) m_wbs++;
            m_fly = e_rd ? m_next : -1;
            if (e_rd) m_next++;
            if (m_wbs == N) begin m_mode = 0; m_done = 1; end
         end
         2: m_mode = 3;
         default: m_mode = 0;
      endcase
      if (pre_en) gram[pre_addr] = pre_data;
      if (!rst_n) begin
         m_mode = 0; m_done = 0; m_fly = -1; m_q.delete();
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preset(input int a, input logic [W-1:0] d);
      pre_en = 1; pre_addr = a[AW-1:0]; pre_data = d;
      tick();
      pre_en = 0;
   endtask

   task automatic step(output int t0);
      step_start = 1;
      tick();
      t0 = cyc;
      step_start = 0;
   endtask

   task automatic wait_done(input int limit, output int dc);
      int n;
      n = 0; dc = -1;
      while (n < limit && dc < 0) begin
         @(negedge clk);
         if (step_done) dc = cyc;
         n++;
      end
      checks++;
      if (dc < 0) begin
         failures++;
         $display("FAIL done_timeout: no step_done within %0d cycles", limit);
      end
      tick();
   endtask

   task automatic inject(input int a, input logic [IW-1:0] c,
                         output int acc);
      int n;
      inj_valid = 1; inj_addr = a[AW-1:0]; inj_current = c;
      acc = -1; n = 0;
      while (n < 50 && acc < 0) begin
         @(negedge clk);
         if (inj_ready) acc = cyc;
         n++;
      end
      tick();
      inj_valid = 0;
      checks++;
      if (acc < 0) begin
         failures++;
         $display("FAIL inj_timeout: injection to %0d never accepted", a);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, dc, dn0, r0, b0, a1, a2, n;
      rst_n = 0; step_start = 0; spk_ready = 0;
      inj_valid = 0; inj_addr = '0; inj_current = '0;
      pre_en = 0; pre_addr = '0; pre_data = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1;
      armed = 1;

      // reset values
      @(negedge clk);
      chk("rst_busy", step_busy, 0);
      chk("rst_done", step_done, 0);
      chk("rst_rd_en", mem_rd_en, 0);
      chk("rst_wr_en", mem_wr_en, 0);
      chk("rst_rd_addr", mem_rd_addr, 0);
      chk("rst_wr_addr", mem_wr_addr, 0);
      chk("rst_wr_data", mem_wr_data, 0);
      chk("rst_proc_in", proc_in, 0);
      chk("rst_spk_valid", spk_valid, 0);
      chk("rst_spk_addr", spk_addr, 0);
      chk("rst_inj_ready", inj_ready, 1);
      tick();

      // plain sweep, nobody fires
      for (int i = 0; i < N; i++)
         preset(i, {20'(256 + i), 20'(512 + i), 16'(16 + i)});
      spk_ready = 1;
      b0 = rx.size(); dn0 = done_cnt;
      step(t0);
      wait_done(40, dc);
      repeat (2) tick();
      chk("t1_latency", dc - t0, N + 1);
      chk("t1_no_spikes", rx.size() - b0, 0);
      chk("t1_one_done", done_cnt - dn0, 1);
      chk("t1_ram0", ram[0], {20'h00101, 20'h00202, 16'h0010});
      chk("t1_ram7", ram[7], {20'h00108, 20'h00209, 16'h0017});

      // neurons 2, 5, 7 fire
      for (int i = 0; i < N; i++)
         if (i == 2 || i == 5 || i == 7)
            preset(i, {20'(32'h80000 + i), 20'h00000, 16'h0000});
         else
            preset(i, {20'h00100, 20'h00000, 16'h0000});
      b0 = rx.size();
      step(t0);
      wait_done(40, dc);
      repeat (3) tick();
      chk("t2_spike_cnt", rx.size() - b0, 3);
      chk("t2_spike0", rx[b0], 2);
      chk("t2_spike1", rx[b0 + 1], 5);
      chk("t2_spike2", rx[b0 + 2], 7);

      // all fire with consumer stalled until cycle 20
      for (int i = 0; i < N; i++)
         preset(i, {20'(32'h80000 + i), 20'(i), 16'(i)});
      spk_ready = 0;
      b0 = rx.size(); r0 = rd_cnt; dn0 = done_cnt;
      step(t0);
      repeat (19) tick();
      chk("t3_reads_stalled", rd_cnt - r0, 4);
      chk("t3_fifo_peak", m_qmax, 4);
      spk_ready = 1;
      wait_done(100, dc);
      repeat (8) tick();
      chk("t3_spike_cnt", rx.size() - b0, N);
      n = (rx.size() - b0 < N) ? rx.size() - b0 : N;
      for (int i = 0; i < n; i++)
         chk("t3_spike_order", rx[b0 + i], i);
      chk("t3_one_done", done_cnt - dn0, 1);

      // saturating injections
      preset(3, {20'h12345, 20'h6789A, 16'h7FF0});
      inject(3, 16'h0020, a1);
      repeat (3) tick();
      chk("t4_sat_pos", ram[3], {20'h12345, 20'h6789A, 16'h7FFF});
      preset(3, {20'h12345, 20'h6789A, 16'h8005});
      inject(3, 16'hFFF0, a1);
      repeat (3) tick();
      chk("t4_sat_neg", ram[3], {20'h12345, 20'h6789A, 16'h8000});
      preset(4, {20'hABCDE, 20'h01234, 16'h0100});
      inject(4, 16'hFFFF, a1);
      repeat (3) tick();
      chk("t4_no_sat", ram[4], {20'hABCDE, 20'h01234, 16'h00FF});

      // back-to-back injections
      preset(5, {20'h00005, 20'h00006, 16'h0001});
      preset(6, {20'h00007, 20'h00008, 16'h7FFF});
      inject(5, 16'h0002, a1);
      inject(6, 16'h0001, a2);
      repeat (3) tick();
      chk("t4_b2b_gap", a2 - a1, 3);
      chk("t4_b2b_ram5", ram[5], {20'h00005, 20'h00006, 16'h0003});
      chk("t4_b2b_ram6", ram[6], {20'h00007, 20'h00008, 16'h7FFF});

      // step_start ignored during injection write, taken next cycle
      preset(2, {20'h00100, 20'h00000, 16'h0010});
      inject(2, 16'h0003, a1);
      tick();
      step_start = 1;
      tick();
      dn0 = done_cnt;
      step(t0);
      wait_done(40, dc);
      repeat (3) tick();
      chk("t4_step_after_inj", dc - t0, N + 1);
      chk("t4_inj_then_sweep", ram[2][15:0], 16'h0013);
      chk("t4_one_done", done_cnt - dn0, 1);

      // step and injection together, plus ignored mid-sweep step_start
      preset(1, {20'h00100, 20'h00200, 16'h0005});
      dn0 = done_cnt;
      inj_valid = 1; inj_addr = 4'd1; inj_current = 16'h0005;
      step(t0);
      repeat (3) tick();
      step_start = 1;
      tick();
      step_start = 0;
      a1 = -1; n = 0;
      while (n < 40 && a1 < 0) begin
         @(negedge clk);
         if (inj_ready) a1 = cyc;
         n++;
      end
      tick();
      inj_valid = 0;
      repeat (4) tick();
      chk("t5_inj_waited", a1 > t0 + N, 1);
      chk("t5_one_done", done_cnt - dn0, 1);
      chk("t5_ram1", ram[1], {20'h00101, 20'h00202, 16'h000A});

      // reset in cycle 4 of a sweep, then a clean sweep
      for (int i = 0; i < N; i++)
         preset(i, {20'(32'h80000 + i), 20'(i), 16'(i)});
      spk_ready = 0;
      step(t0);
      repeat (3) tick();
      rst_n = 0;
      tick();
      rst_n = 1;
      @(negedge clk);
      chk("t6_busy", step_busy, 0);
      chk("t6_rd_en", mem_rd_en, 0);
      chk("t6_wr_en", mem_wr_en, 0);
      chk("t6_spk_valid", spk_valid, 0);
      chk("t6_proc_in", proc_in, 0);
      tick();
      spk_ready = 1;
      dn0 = done_cnt;
      step(t0);
      wait_done(40, dc);
      repeat (8) tick();
      chk("t6_latency", dc - t0, N + 1);
      chk("t6_one_done", done_cnt - dn0, 1);

      for (int i = 0; i < N; i++)
         chk("final_ram", ram[i], gram[i]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
